requant_stream: RTL
===================

REQUANT_STREAM -- requirements
Module: requant_stream

Interface
REQ-001 SHALL have parameter IN_W, default 16, input sample width (unsigned; power of two, 8..32).
REQ-002 SHALL have parameter OUT_W, default 8, output sample width (unsigned; OUT_W < IN_W).
REQ-003 SHALL have parameter NCH, default 4, number of lanes processed in parallel per beat.
REQ-004 SHALL have parameter SCALE_W, default 8, width of the linear-mode multiplier.
REQ-005 SHALL have ports: iclk input 1 clock; irst input 1 reset (synchronous, active-high).
REQ-006 SHALL have port ivalid input 1: upstream beat valid.
REQ-007 SHALL have port oready output 1: block can accept a beat.
REQ-008 SHALL have port idata input NCH*IN_W: lane k occupies bits [k*IN_W +: IN_W].
REQ-009 SHALL have port imode input 1: 0 = lin, 1 = log; sampled with the beat.
REQ-010 SHALL have port iscale input SCALE_W and port ishift input 5: lin-mode scale and right shift; sampled with the beat.
REQ-011 SHALL have port ovalid output 1: output beat valid.
REQ-012 SHALL have port iready input 1: downstream accepts the beat.
REQ-013 SHALL have port odata output NCH*OUT_W, with the same lane packing as idata.

Function
REQ-014 SHALL transfer a beat in when ivalid & oready, and out when ovalid & iready.
REQ-015 SHALL use a 2-stage elastic pipeline: stage 1 = multiply/MSB-detect, stage 2 = round/shift/saturate/pack; latency 2 cycles from input handshake to ovalid with no backpressure.
REQ-016 SHALL let each stage load whenever it is empty or its content leaves in the same cycle; full throughput of 1 beat/cycle while iready = 1.
REQ-017 SHALL hold odata/ovalid stable while ovalid & ~iready; no beat is dropped or duplicated.
REQ-018 SHALL drive oready low only when both stages are full and iready = 0.
REQ-019 SHALL, in lin mode, compute per lane p = v*iscale (IN_W+SCALE_W bits); r = (p + 2^(ishift-1)) >> ishift, with no rounding term when ishift = 0; out = min(r, 2^OUT_W-1).
REQ-020 SHALL, in log mode, output 0 for v = 0 or 1; else e = index of MSB of v, E_W = log2(IN_W), M_W = OUT_W-E_W, m = the M_W bits immediately below the MSB (zero-padded on the right when e < M_W); out = {e[E_W-1:0], m}.
REQ-021 SHALL carry imode/iscale/ishift through the pipeline with their beat, so a change between beats affects only later beats.
REQ-022 SHALL process all NCH lanes identically and independently within one beat.

Reset
REQ-023 SHALL, on irst, clear both stage-valid flags: ovalid = 0, odata = 0, oready = 1 the next cycle; beats in flight are discarded.
REQ-024 SHALL ignore ivalid during the cycle irst is high.

Configuration
REQ-025 SHALL, with REQUANT_SAT_CNT_EN defined, add output osat_cnt[31:0]: counts lane samples clamped by REQ-019 in beats leaving the block, sticky at 0xFFFFFFFF, cleared by irst.
REQ-026 SHALL, without REQUANT_SAT_CNT_EN, have neither the osat_cnt port nor its logic.

Structure
REQ-027 SHALL place the mode enum (REQ_LIN, REQ_LOG), the E_W/M_W derivation functions and the lane-width localparams in package requant_pkg.
REQ-028 SHALL implement per-lane arithmetic in sub-module requant_lane (two register stages plus clamp flag), instantiated NCH times by generate.

Verification (IN_W=16, OUT_W=8, NCH=4)
REQ-029 SHALL check lin, iscale=1, ishift=8: lane 0x0180 -> 0x02; 0x007F -> 0x00; 0xFFFF -> 0xFF with clamp counted; ovalid 2 cycles after handshake.
REQ-030 SHALL check log: 0x0000 -> 0x00; 0x0001 -> 0x00; 0x0300 -> 0x98; 0x8000 -> 0xF0; 0xFFFF -> 0xFF.
REQ-031 SHALL check backpressure: 10 back-to-back beats, iready toggling 1/0 every cycle -> all 10 outputs in order, none lost or repeated, oready low only with both stages full.
REQ-032 SHALL check mode/scale switching on consecutive beats (lin iscale=2 ishift=1 on 0x0064, then log on 0x0064) -> 0x64 then 0x69.
REQ-033 SHALL check irst asserted with 2 beats in flight -> ovalid = 0 and oready = 1 the next cycle, no stale beat emitted afterwards.
REQ-034 SHALL check with REQUANT_SAT_CNT_EN: 3 beats of all-0xFFFF lanes, lin iscale=1 ishift=0 -> osat_cnt = 12.

Source files
------------

// File: rtl/requant_pkg.sv
// requant_pkg: shared definitions for the requant_stream block.
//   - req_mode_e : per-beat requantisation mode (linear scale/shift or log2 code)
//   - SHIFT_W    : width of the linear-mode right-shift control
//   - calc_e_w / calc_m_w : exponent and mantissa field widths of the log code
//   - calc_sum_w : width of the linear-mode rounding adder, wide enough that the
//                  largest rounding constant (2^30) never overflows
package requant_pkg;

  typedef enum logic {
    REQ_LIN = 1'b0,
    REQ_LOG = 1'b1
  } req_mode_e;

  localparam int SHIFT_W   = 5;
  localparam int SHIFT_MAX = (1 << SHIFT_W) - 1;

  function automatic int calc_e_w(input int in_w);
    return $clog2(in_w);
  endfunction

  function automatic int calc_m_w(input int in_w, input int out_w);
    return out_w - $clog2(in_w);
  endfunction

  function automatic int calc_sum_w(input int p_w);
    return ((p_w > SHIFT_MAX) ? p_w : SHIFT_MAX) + 1;
  endfunction

endpackage

// File: rtl/requant_lane.sv
// requant_lane: datapath for one lane of requant_stream.
//   Stage 1 registers the linear product (or the raw sample in log mode) and
//   the MSB index of the sample; stage 2 registers the rounded/shifted/clamped
//   or log-coded output byte.
// Ports:
//   iclk               clock
//   ien_p1 / ien_p2    load enables of the two register stages (from the top)
//   ival               input sample of this lane
//   imode / iscale     mode and linear scale of the beat entering stage 1
//   imode_p1/ishift_p1 mode and shift of the beat held in stage 1
//   oout               stage-2 output sample
//   oclamp             stage-2 clamp flag (only with REQUANT_SAT_CNT_EN)
module requant_lane
  import requant_pkg::*;
#(
  parameter int IN_W    = 16,
  parameter int OUT_W   = 8,
  parameter int SCALE_W = 8
) (
  input  logic               iclk,
  input  logic               ien_p1,
  input  logic               ien_p2,
  input  logic [IN_W-1:0]    ival,
  input  logic               imode,
  input  logic [SCALE_W-1:0] iscale,
  input  logic               imode_p1,
  input  logic [SHIFT_W-1:0] ishift_p1,
  output logic [OUT_W-1:0]   oout
`ifdef REQUANT_SAT_CNT_EN
  ,
  output logic               oclamp
`endif
);

  localparam int E_W   = calc_e_w(IN_W);
  localparam int M_W   = calc_m_w(IN_W, OUT_W);
  localparam int P_W   = IN_W + SCALE_W;
  localparam int SUM_W = calc_sum_w(P_W);
  localparam logic [SUM_W-1:0] OUT_MAX = SUM_W'({OUT_W{1'b1}});

  function automatic logic [SUM_W-1:0] round_shift(input logic [P_W-1:0] p,
                                                   input logic [SHIFT_W-1:0] sh);
    logic [SUM_W-1:0] half;
    half = (sh == {SHIFT_W{1'b0}}) ? {SUM_W{1'b0}} : (SUM_W'(1) << (sh - SHIFT_W'(1)));
    return (SUM_W'(p) + half) >> sh;
  endfunction

  function automatic logic [OUT_W-1:0] saturate(input logic [SUM_W-1:0] r);
    return (r > OUT_MAX) ? {OUT_W{1'b1}} : r[OUT_W-1:0];
  endfunction

  logic [P_W-1:0] w_prod;
  logic [E_W-1:0] w_msb;
  logic           w_small;

  always_comb begin
    w_prod  = (req_mode_e'(imode) == REQ_LOG) ? P_W'(ival) : P_W'(ival) * P_W'(iscale);
    w_msb   = {E_W{1'b0}};
    for (int i = 0; i < IN_W; i++) begin
      if (ival[i]) w_msb = E_W'(i);
    end
    w_small = (ival < IN_W'(2));
  end

  // ---- stage 1 boundary: product / MSB index ----
  logic [P_W-1:0] r_prod_p1;
  logic [E_W-1:0] r_msb_p1;
  logic           r_small_p1;

  always_ff @(posedge iclk) begin
    if (ien_p1) begin
      r_prod_p1  <= w_prod;
      r_msb_p1   <= w_msb;
      r_small_p1 <= w_small;
    end
  end

  logic [SUM_W-1:0] w_r;
  logic [IN_W-1:0]  w_frac;
  logic [M_W-1:0]   w_mant;
  logic [OUT_W-1:0] w_out;

  // The mantissa is the fraction below the MSB, left-aligned into M_W bits:
  // shifting it up by M_W and back down by the MSB index also zero-pads small
  // exponents on the right.
  always_comb begin
    w_r    = round_shift(r_prod_p1, ishift_p1);
    w_frac = r_prod_p1[IN_W-1:0] & ~(IN_W'(1) << r_msb_p1);
    w_mant = M_W'({w_frac, {M_W{1'b0}}} >> r_msb_p1);
    if (req_mode_e'(imode_p1) == REQ_LOG) begin
      w_out = r_small_p1 ? {OUT_W{1'b0}} : {r_msb_p1, w_mant};
    end else begin
      w_out = saturate(w_r);
    end
  end

  // ---- stage 2 boundary: packed output sample ----
  logic [OUT_W-1:0] r_out_p2;

  always_ff @(posedge iclk) begin
    if (ien_p2) r_out_p2 <= w_out;
  end

  assign oout = r_out_p2;

`ifdef REQUANT_SAT_CNT_EN
  logic w_clamp;
  logic r_clamp_p2;

  assign w_clamp = (req_mode_e'(imode_p1) == REQ_LIN) && (w_r > OUT_MAX);

  always_ff @(posedge iclk) begin
    if (ien_p2) r_clamp_p2 <= w_clamp;
  end

  assign oclamp = r_clamp_p2;
`endif

endmodule

// File: rtl/requant_stream.sv
// requant_stream: NCH-lane requantiser (IN_W -> OUT_W) behind a 2-stage
// elastic valid/ready pipeline. Linear mode: (v*iscale + round) >> ishift,
// clamped to OUT_W bits. Log mode: {MSB index, M_W mantissa bits}.
// Optional feature macro: REQUANT_SAT_CNT_EN adds osat_cnt, a sticky 32-bit
// count of clamped lane samples in beats leaving the block.
// Ports:
//   iclk, irst          clock, synchronous active-high reset
//   ivalid/oready/idata upstream beat (lane k at [k*IN_W +: IN_W])
//   imode/iscale/ishift per-beat controls, travel with the beat
//   ovalid/iready/odata downstream beat (lane k at [k*OUT_W +: OUT_W])
//   osat_cnt            clamp counter (only with REQUANT_SAT_CNT_EN)
module requant_stream
  import requant_pkg::*;
#(
  parameter int IN_W    = 16,
  parameter int OUT_W   = 8,
  parameter int NCH     = 4,
  parameter int SCALE_W = 8
) (
  input  logic                   iclk,
  input  logic                   irst,
  input  logic                   ivalid,
  output logic                   oready,
  input  logic [NCH*IN_W-1:0]    idata,
  input  logic                   imode,
  input  logic [SCALE_W-1:0]     iscale,
  input  logic [SHIFT_W-1:0]     ishift,
  output logic                   ovalid,
  input  logic                   iready,
  output logic [NCH*OUT_W-1:0]   odata
`ifdef REQUANT_SAT_CNT_EN
  ,
  output logic [31:0]            osat_cnt
`endif
);

  logic r_vld_p1;
  logic r_vld_p2;
  logic w_ld_p1;
  logic w_ld_p2;
  logic w_en_p1;
  logic w_en_p2;

  // A stage may load when it is empty or its content moves on this cycle.
  assign w_ld_p2 = ~r_vld_p2 | iready;
  assign w_ld_p1 = ~r_vld_p1 | w_ld_p2;
  assign w_en_p1 = w_ld_p1 & ivalid;
  assign w_en_p2 = w_ld_p2 & r_vld_p1;
  assign oready  = w_ld_p1;
  assign ovalid  = r_vld_p2;

  // ---- stage 1 boundary: beat controls ----
  logic                r_mode_p1;
  logic [SHIFT_W-1:0]  r_shift_p1;

  always_ff @(posedge iclk) begin
    if (irst) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      if (w_ld_p1) r_vld_p1 <= ivalid;
      if (w_ld_p2) r_vld_p2 <= r_vld_p1;
    end
  end

  always_ff @(posedge iclk) begin
    if (w_en_p1) begin
      r_mode_p1  <= imode;
      r_shift_p1 <= ishift;
    end
  end

  logic [OUT_W-1:0] w_out [NCH];
`ifdef REQUANT_SAT_CNT_EN
  logic [NCH-1:0] w_clamp;
`endif

  for (genvar k = 0; k < NCH; k++) begin : g_lane
    requant_lane #(
      .IN_W    (IN_W),
      .OUT_W   (OUT_W),
      .SCALE_W (SCALE_W)
    ) u_lane (
      .iclk      (iclk),
      .ien_p1    (w_en_p1),
      .ien_p2    (w_en_p2),
      .ival      (idata[k*IN_W +: IN_W]),
      .imode     (imode),
      .iscale    (iscale),
      .imode_p1  (r_mode_p1),
      .ishift_p1 (r_shift_p1),
      .oout      (w_out[k])
`ifdef REQUANT_SAT_CNT_EN
      ,
      .oclamp    (w_clamp[k])
`endif
    );

    // Data registers are not reset; an empty output stage reads as zero.
    assign odata[k*OUT_W +: OUT_W] = r_vld_p2 ? w_out[k] : {OUT_W{1'b0}};
  end

`ifdef REQUANT_SAT_CNT_EN
  logic [31:0] w_nclamp;
  logic [32:0] w_cnt_sum;
  logic [31:0] r_sat_cnt;

  always_comb begin
    w_nclamp = 32'd0;
    for (int k = 0; k < NCH; k++) begin
      w_nclamp = w_nclamp + 32'(w_clamp[k]);
    end
    w_cnt_sum = {1'b0, r_sat_cnt} + {1'b0, w_nclamp};
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      r_sat_cnt <= 32'd0;
    end else if (r_vld_p2 && iready) begin
      r_sat_cnt <= w_cnt_sum[32] ? 32'hFFFF_FFFF : w_cnt_sum[31:0];
    end
  end

  assign osat_cnt = r_sat_cnt;
`endif

endmodule
